// File: rtl/vga_pkg.sv
// Shared constants, pixel type and colour-dimming helper for the scan-doubler.
// dim() is only used when VGA_SCANLINES_EN is defined.
package vga_pkg;

  localparam int LINE_LEN  = 360;
  localparam int PIX_W     = 6;
  localparam int RD_DIV    = 2;
  localparam int ADDR_W    = $clog2(LINE_LEN);
  localparam int RAM_DEPTH = 2 * LINE_LEN;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int DIV_W     = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pix_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

  // Bank 0 occupies entries 0..LINE_LEN-1, bank 1 the next LINE_LEN entries.
  function automatic logic [RAM_AW-1:0] ram_idx(input logic bank,
                                                input logic [ADDR_W-1:0] addr);
    return RAM_AW'(addr) + (bank ? RAM_AW'(LINE_LEN) : RAM_AW'(0));
  endfunction

  function automatic pix_t dim(input pix_t p);
    pix_t d;
    d.r = p.r >> 1;
    d.g = p.g >> 1;
    d.b = p.b >> 1;
    return d;
  endfunction

endpackage

// File: rtl/vga_linebuf.sv
// Ping-pong line store: simple dual-port RAM, one write port and one
// registered read port, written so it maps onto a block RAM.
module vga_linebuf
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [RAM_AW-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_scandbl_rd.sv
// vga_scandbl_rd: captures one TV line per bank and replays the other bank twice.
// Define VGA_SCANLINES_EN to halve each colour on the second replay of a line.
module vga_scandbl_rd
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_start,
  input  logic             pix_stb,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             scanout_start,
  output logic [PIX_W-1:0] vga_pix,
  output logic             vga_act
);

  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  rd_state_t         state, state_n;
  logic              rd_bank, rd_bank_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [DIV_W-1:0]  div, div_n;
  logic              act_d1;
  logic [PIX_W-1:0]  rdata, out_pix;

  assign wr_en = pix_stb && (wr_addr < ADDR_W'(LINE_LEN));

  // The write uses the pre-swap bank/address, so a strobe coincident with
  // hsync_start lands at the end of the line being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (hsync_start) begin
      wr_bank <= ~wr_bank;
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    rd_bank_n = rd_bank;
    rd_addr_n = rd_addr;
    div_n     = div;
    if (scanout_start) begin
      state_n   = RD_RUN;
      rd_bank_n = hsync_start ? wr_bank : ~wr_bank;
      rd_addr_n = '0;
      div_n     = '0;
    end else if (state == RD_RUN) begin
      if (div == DIV_W'(RD_DIV - 1)) begin
        div_n = '0;
        if (rd_addr == ADDR_W'(LINE_LEN - 1)) state_n = RD_IDLE;
        else rd_addr_n = rd_addr + 1'b1;
      end else begin
        div_n = div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
      div     <= '0;
    end else begin
      state   <= state_n;
      rd_bank <= rd_bank_n;
      rd_addr <= rd_addr_n;
      div     <= div_n;
    end
  end

  // The RAM is addressed with the next-state pointer so that RAM latency plus
  // the output register put pixel 0 on the pins two cycles after scanout_start.
  vga_linebuf u_linebuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ram_idx(wr_bank, wr_addr)),
    .wdata (pix_in),
    .raddr (ram_idx(rd_bank_n, rd_addr_n)),
    .rdata (rdata)
  );

`ifdef VGA_SCANLINES_EN
  logic rd_half, half_eff, dim_line, dim_d1;

  assign half_eff = hsync_start ? 1'b0 : rd_half;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_half  <= 1'b0;
      dim_line <= 1'b0;
      dim_d1   <= 1'b0;
    end else begin
      if (scanout_start) begin
        rd_half  <= ~half_eff;
        dim_line <= half_eff;
      end else if (hsync_start) begin
        rd_half <= 1'b0;
      end
      dim_d1 <= scanout_start ? half_eff : dim_line;
    end
  end

  assign out_pix = dim_d1 ? dim(pix_t'(rdata)) : rdata;
`else
  assign out_pix = rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      act_d1  <= 1'b0;
      vga_act <= 1'b0;
      vga_pix <= '0;
    end else begin
      act_d1  <= (state_n == RD_RUN);
      vga_act <= act_d1;
      vga_pix <= act_d1 ? out_pix : '0;
    end
  end

endmodule
